// File: rtl/pi_ratio_divider_if.sv
// Operand/result bundle for pi_ratio_divider: start/ack request-acknowledge handshake.
// The master drives operands, start and ack; the slave (divider) returns the result and its status.
interface pi_ratio_divider_if;
    logic [31:0] innerPoints;
    logic [31:0] totalPoints;
    logic        start;
    logic        ack;
    logic [31:0] piFixed;
    logic        resultValid;
    logic        busy;
    logic        divByZero;
    logic        overflow;

    modport master (
        output innerPoints, totalPoints, start, ack,
        input  piFixed, resultValid, busy, divByZero, overflow
    );

    modport slave (
        input  innerPoints, totalPoints, start, ack,
        output piFixed, resultValid, busy, divByZero, overflow
    );
endinterface

// File: rtl/pi_ratio_divider.sv
// Fixed-point 4*inner/total via 64-step restoring division; result 64 edges after start (same edge for total=0).
// Backpressure: result and flags held in DONE until ack; start is only taken in IDLE.
module pi_ratio_divider #(
    parameter int FRAC_BITS = 28
) (
    input  logic              clk,
    input  logic              reset,
    pi_ratio_divider_if.slave bus
);

    localparam int SHIFT = FRAC_BITS + 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DIV  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [31:0] total_q;
    logic [32:0] rem;
    logic [63:0] quo;
    logic [5:0]  cnt;
    logic [31:0] pi_q;
    logic        dbz_q;
    logic        ovf_q;

    logic [33:0] rem_sh;
    logic [33:0] diff;
    logic        ge;
    logic [32:0] rem_nxt;
    logic [63:0] quo_nxt;
    logic        accept;
    logic        zero_div;
    logic        last_iter;

    assign accept    = (state == IDLE) && bus.start;
    assign zero_div  = (bus.totalPoints == 32'd0);
    assign last_iter = (state == DIV) && (cnt == 6'd63);

    // quo starts as the dividend; its MSBs shift into the remainder while quotient bits shift in at the LSB
    always_comb begin
        rem_sh  = {rem, quo[63]};
        diff    = rem_sh - {2'b00, total_q};
        ge      = rem_sh[33] | ~diff[33];
        rem_nxt = ge ? diff[32:0] : rem_sh[32:0];
        quo_nxt = {quo[62:0], ge};
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (bus.start) state_nxt = zero_div ? DONE : DIV;
            DIV:  if (last_iter) state_nxt = DONE;
            DONE: if (bus.ack)   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            total_q <= '0;
            rem     <= '0;
            quo     <= '0;
            cnt     <= '0;
            pi_q    <= '0;
            dbz_q   <= 1'b0;
            ovf_q   <= 1'b0;
        end else if (accept) begin
            total_q <= bus.totalPoints;
            rem     <= '0;
            quo     <= 64'(bus.innerPoints) << SHIFT;
            cnt     <= '0;
            pi_q    <= '0;
            dbz_q   <= zero_div;
            ovf_q   <= 1'b0;
        end else if (state == DIV) begin
            rem <= rem_nxt;
            quo <= quo_nxt;
            cnt <= cnt + 6'd1;
            if (last_iter) begin
                if (quo_nxt[63:32] == 32'd0) begin
                    pi_q <= quo_nxt[31:0];
                end else begin
                    pi_q  <= 32'hFFFF_FFFF;
                    ovf_q <= 1'b1;
                end
            end
        end
    end

    assign bus.piFixed     = pi_q;
    assign bus.resultValid = (state == DONE);
    assign bus.busy        = (state == DIV);
    assign bus.divByZero   = dbz_q;
    assign bus.overflow    = ovf_q;

endmodule

// File: tb/tb_pi_ratio_divider.sv
// Directed bench for pi_ratio_divider: driver pushes expected results into a scoreboard queue,
// a negedge monitor pops and compares whenever resultValid rises and checks the result stays put while held.
module tb_pi_ratio_divider;

    typedef struct {
        logic [31:0] pi;
        logic        dbz;
        logic        ovf;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    int   errors = 0;
    int   checks = 0;
    exp_t sb[$];
    exp_t cur;
    logic prev_rv;

    pi_ratio_divider_if bus ();

    pi_ratio_divider #(.FRAC_BITS(28)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: compare on the rising edge of resultValid, then check stability while it is held.
    initial begin
        prev_rv = 1'b0;
        cur.pi  = '0;
        cur.dbz = 1'b0;
        cur.ovf = 1'b0;
        forever begin
            @(negedge clk);
            if (reset) begin
                prev_rv = 1'b0;
            end else begin
                chk("busy_rv_exclusive", {31'd0, bus.busy & bus.resultValid}, 32'd0);
                if (bus.resultValid && !prev_rv) begin
                    if (sb.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_result: got %h with empty scoreboard", bus.piFixed);
                    end else begin
                        cur = sb.pop_front();
                        chk("piFixed", bus.piFixed, cur.pi);
                        chk("divByZero", {31'd0, bus.divByZero}, {31'd0, cur.dbz});
                        chk("overflow", {31'd0, bus.overflow}, {31'd0, cur.ovf});
                    end
                end else if (bus.resultValid) begin
                    chk("piFixed_hold", bus.piFixed, cur.pi);
                    chk("flags_hold", {30'd0, bus.divByZero, bus.overflow}, {30'd0, cur.dbz, cur.ovf});
                end
                prev_rv = bus.resultValid;
            end
        end
    end

    // exp_edges: rising edges after the start-sampling edge until resultValid is seen.
    task automatic run_op(input logic [31:0] inner, input logic [31:0] total,
                          input logic [31:0] exp_pi, input logic dbz, input logic ovf,
                          input int exp_edges, input int hold,
                          input bit disturb, input bit start_with_ack);
        int   n;
        int   bcnt;
        exp_t e;
        bus.innerPoints = inner;
        bus.totalPoints = total;
        bus.start       = 1'b1;
        e.pi  = exp_pi;
        e.dbz = dbz;
        e.ovf = ovf;
        sb.push_back(e);
        @(posedge clk); #1;
        bus.start = 1'b0;
        n    = 0;
        bcnt = 0;
        while (!bus.resultValid && n < 200) begin
            if (bus.busy) bcnt++;
            if (disturb && n == 10) begin
                bus.innerPoints = 32'd1;
                bus.totalPoints = 32'd3;
                bus.start       = 1'b1;
            end else if (disturb && n == 12) begin
                bus.start = 1'b0;
                bus.ack   = 1'b1;
            end else begin
                bus.start = 1'b0;
                bus.ack   = 1'b0;
            end
            @(posedge clk); #1;
            n++;
        end
        chk("latency", n, exp_edges);
        chk("busy_cycles", bcnt, exp_edges);
        for (int i = 0; i < hold; i++) begin
            bus.start = disturb;
            @(posedge clk); #1;
        end
        bus.ack   = 1'b1;
        bus.start = start_with_ack;
        @(posedge clk); #1;
        bus.ack   = 1'b0;
        bus.start = 1'b0;
        chk("rv_after_ack", {31'd0, bus.resultValid}, 32'd0);
        chk("busy_after_ack", {31'd0, bus.busy}, 32'd0);
        chk("pi_idle_hold", bus.piFixed, exp_pi);
        @(posedge clk); #1;
    endtask

    initial begin
        reset           = 1'b1;
        bus.innerPoints = '0;
        bus.totalPoints = '0;
        bus.start       = 1'b0;
        bus.ack         = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_piFixed", bus.piFixed, 32'd0);
        chk("reset_outputs", {28'd0, bus.resultValid, bus.busy, bus.divByZero, bus.overflow}, 32'd0);
        reset = 1'b0;
        @(posedge clk); #1;

        run_op(32'd785, 32'd1000, 32'h323D_70A3, 1'b0, 1'b0, 64, 2, 1'b0, 1'b0);
        run_op(32'd5, 32'd5, 32'h4000_0000, 1'b0, 1'b0, 64, 0, 1'b0, 1'b0);
        run_op(32'd0, 32'd7, 32'h0000_0000, 1'b0, 1'b0, 64, 1, 1'b0, 1'b0);
        run_op(32'd123, 32'd0, 32'h0000_0000, 1'b1, 1'b0, 0, 2, 1'b0, 1'b0);
        run_op(32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 1'b0, 1'b1, 64, 1, 1'b0, 1'b0);
        run_op(32'd3, 32'd1, 32'hC000_0000, 1'b0, 1'b0, 64, 0, 1'b0, 1'b0);
        run_op(32'd4, 32'd1, 32'hFFFF_FFFF, 1'b0, 1'b1, 64, 0, 1'b0, 1'b0);
        run_op(32'd3, 32'd2, 32'h6000_0000, 1'b0, 1'b0, 64, 0, 1'b0, 1'b0);

        // Abort a division 20 edges in; no result may appear.
        bus.innerPoints = 32'd785;
        bus.totalPoints = 32'd1000;
        bus.start       = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        chk("busy_before_abort", {31'd0, bus.busy}, 32'd1);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        chk("abort_piFixed", bus.piFixed, 32'd0);
        chk("abort_outputs", {28'd0, bus.resultValid, bus.busy, bus.divByZero, bus.overflow}, 32'd0);
        repeat (70) @(posedge clk);
        #1;
        chk("abort_no_result", {31'd0, bus.resultValid}, 32'd0);

        run_op(32'd7, 32'd3, 32'h9555_5555, 1'b0, 1'b0, 64, 0, 1'b0, 1'b0);
        run_op(32'd785, 32'd1000, 32'h323D_70A3, 1'b0, 1'b0, 64, 10, 1'b1, 1'b1);

        repeat (5) @(posedge clk);
        #1;
        chk("scoreboard_empty", sb.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end

endmodule

// File: doc/pi_ratio_divider.md
PI_RATIO_DIVIDER -- requirements
Module: pi_ratio_divider

Interface
REQ-001 SHALL have parameter FRAC_BITS, default 28, giving the number of fraction bits in piFixed; legal range 0..29.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port innerPoints  input  32  count of points inside the circle, unsigned.
REQ-005 SHALL have port totalPoints  input  32  count of all points, unsigned.
REQ-006 SHALL have port start  input  1  request to begin a division; sampled only in IDLE.
REQ-007 SHALL have port ack  input  1  consumer acknowledge of the result; sampled only in DONE.
REQ-008 SHALL have port piFixed  output  32  unsigned fixed-point estimate of 4*innerPoints/totalPoints with FRAC_BITS fraction bits.
REQ-009 SHALL have port resultValid  output  1  high while in DONE.
REQ-010 SHALL have port busy  output  1  high while in DIV.
REQ-011 SHALL have port divByZero  output  1  result flag: totalPoints was 0.
REQ-012 SHALL have port overflow  output  1  result flag: the quotient exceeded 32 bits and was saturated.

Function
REQ-013 SHALL implement a three-state machine: IDLE, DIV and DONE.
REQ-014 SHALL, in IDLE with start=1, latch innerPoints and totalPoints into internal registers, clear divByZero and overflow, and move to DIV; if the latched totalPoints is 0, SHALL instead move directly to DONE with piFixed=0 and divByZero=1.
REQ-015 SHALL form the dividend as a 64-bit value equal to the latched innerPoints shifted left by FRAC_BITS+2, and the divisor as the latched totalPoints.
REQ-016 SHALL perform radix-2 restoring division in DIV, one quotient bit per cycle, MSB first, for exactly 64 cycles.
REQ-017 SHALL use a 33-bit partial remainder and a 64-bit quotient register, and SHALL use a 6-bit iteration counter that counts 0..63.
REQ-018 SHALL complete the 64th iteration on the 64th rising edge after the start-sampling edge, and SHALL enter DONE on that edge; start-to-resultValid latency is 64 cycles, or 1 cycle for the divide-by-zero case.
REQ-019 SHALL, on entering DONE from DIV, set piFixed to quotient[31:0] if quotient[63:32]==0; otherwise SHALL set piFixed to 32'hFFFF_FFFF and overflow=1.
REQ-020 SHALL hold piFixed, divByZero and overflow stable throughout DONE and IDLE until the next accepted start.
REQ-021 SHALL move from DONE to IDLE on ack=1; resultValid falls on that edge.
REQ-022 SHALL ignore start in DIV and in DONE, and SHALL ignore ack outside DONE.
REQ-023 SHALL be unaffected by changes to innerPoints and totalPoints after the start-sampling edge.
REQ-024 SHALL drive busy=1 exactly in DIV and resultValid=1 exactly in DONE; the two are never high together.
REQ-025 SHALL, when start and ack are both high in DONE, take only ack (move to IDLE); the start is not accepted on that edge.
REQ-026 SHALL, when innerPoints > totalPoints, compute the same arithmetic with no special casing; saturation is the only protection.

Reset
REQ-027 SHALL, on reset=1 at a rising edge, set state=IDLE, piFixed=0, resultValid=0, busy=0, divByZero=0 and overflow=0, and clear the counter, remainder and quotient registers.
REQ-028 SHALL let reset take priority over start and ack, and SHALL abort any division in progress (reset in DIV or DONE returns the block to IDLE with no result).
REQ-029 SHALL enter DIV no earlier than the first edge on which reset=0 and start=1.

Verification
REQ-030 SHALL cover, with FRAC_BITS=28: inner=785, total=1000, start pulse -> busy for 64 cycles, then resultValid=1, piFixed=32'h323D_70A3, both flags 0.
REQ-031 SHALL cover: inner=5, total=5 -> piFixed=32'h4000_0000; and inner=0, total=7 -> piFixed=0; flags 0 in both cases.
REQ-032 SHALL cover: total=0, inner=123 -> resultValid 1 cycle after start, piFixed=0, divByZero=1, busy never high.
REQ-033 SHALL cover: inner=32'hFFFF_FFFF, total=1 -> piFixed=32'hFFFF_FFFF, overflow=1.
REQ-034 SHALL cover: reset asserted 20 cycles into DIV -> next cycle in IDLE, all outputs 0; then a fresh start produces the correct result at full 64-cycle latency.
REQ-035 SHALL cover: operands changed and start re-pulsed during DIV, and resultValid held with ack=0 for 10 cycles -> result matches the original operands, and piFixed stays stable until ack.
